// File: rtl/interp_round_clip_serializer.sv
// interp_round_clip_serializer: rounds/normalises/clips interpolator sums and
// serialises the selected phases onto a one-pixel valid/ready stream.
module interp_round_clip_serializer #(
  parameter int FRAC_BITS = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  full_pel,
  input  logic [31:0] a_value,
  input  logic [31:0] b_value,
  input  logic [31:0] c_value,
  input  logic [3:0]  phase_mask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_pixel,
  output logic [1:0]  out_phase,
  output logic        out_last
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_n;
  logic [3:0] rem, rem_n;
  logic [3:0][7:0] pix;
  logic in_fire;
  // 33-bit intermediate keeps the rounding offset from overflowing
  function automatic logic [7:0] norm(input logic [31:0] v);
    logic signed [32:0] r;
    r = ($signed({v[31], v}) + (33'sd1 <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
    return r[32] ? 8'd0 : (|r[31:8]) ? 8'hff : r[7:0];
  endfunction
  always_comb begin
    out_valid = state == EMIT;
    out_phase = (!out_valid || rem[0]) ? 2'd0 : rem[1] ? 2'd1 : rem[2] ? 2'd2 : 2'd3;
    out_last = out_valid && ((rem & (rem - 4'd1)) == 4'd0);
    out_pixel = out_valid ? pix[out_phase] : 8'h00;
    in_ready = !reset && (!out_valid || (out_ready && out_last));
    in_fire = in_valid && in_ready;
    rem_n = in_fire ? phase_mask : (out_valid && out_ready) ? (rem & (rem - 4'd1)) : rem;
    state_n = (rem_n != 4'd0) ? EMIT : IDLE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rem <= '0;
      pix <= '0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      if (in_fire) pix <= {norm(c_value), norm(b_value), norm(a_value), full_pel};
    end
  end
endmodule
